control_sequencer: RTL and testbench

Hardwired control unit for the single-bus CPU datapath. It fetches each instruction through the datapath, decodes the opcode latched in IR, and drives the datapath control signals one T-step per clock: register enables, bus source selects, ALU operation, memory read/write, PC increment and select-and-encode strobes. It sits beside the datapath and is the only driver of its control inputs.

---
 rtl/ctrl_pkg.sv | 72 +++++++
 rtl/ctrl_decode.sv | 137 +++++++++++++
 rtl/control_sequencer.sv | 85 ++++++++
 tb/tb_control_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared constants for the hardwired control sequencer: opcodes, FSM states,
// control-bus bit positions and the instruction-length lookup.
package ctrl_pkg;

  localparam logic [5:0] ALU_ADD = 6'd3;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_e;

  localparam int RE_HI  = 16;
  localparam int RE_LO  = 17;
  localparam int RE_ZH  = 18;
  localparam int RE_ZL  = 19;
  localparam int RE_PC  = 20;
  localparam int RE_IR  = 21;
  localparam int RE_MDR = 22;
  localparam int RE_MAR = 23;
  localparam int RE_Y   = 24;

  localparam int BS_HI  = 16;
  localparam int BS_LO  = 17;
  localparam int BS_ZH  = 18;
  localparam int BS_ZL  = 19;
  localparam int BS_PC  = 20;
  localparam int BS_MDR = 21;
  localparam int BS_IN  = 22;
  localparam int BS_C   = 23;

  function automatic logic is_alu_rr(input logic [4:0] op);
    return (op >= OP_ADD) && (op <= OP_ROL);
  endfunction

  function automatic logic is_alu_imm(input logic [4:0] op);
    return (op >= OP_ADDI) && (op <= OP_ORI);
  endfunction

  // Final T-step of each instruction; nop and undefined opcodes end at T2.
  function automatic state_e last_step(input logic [4:0] op);
    state_e s;
    s = S_T2;
    if (is_alu_rr(op) || is_alu_imm(op) || op == OP_LDI) s = S_T5;
    else if (op == OP_LD || op == OP_ST) s = S_T7;
    else if (op == OP_MUL || op == OP_DIV || op == OP_BR) s = S_T6;
    else if (op == OP_NEG || op == OP_NOT || op == OP_JAL) s = S_T4;
    else if (op == OP_JR || op == OP_IN || op == OP_OUT ||
             op == OP_MFHI || op == OP_MFLO) s = S_T3;
    return s;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Per-state output decode: maps (T-step, opcode, con) to the datapath
// control strobes. Purely combinational.
module ctrl_decode #(
  parameter logic [5:0] ALU_ADD = 6'd3
) (
  input  logic [3:0]  state,
  input  logic [4:0]  opcode,
  input  logic        con,
  output logic [31:0] reg_enable,
  output logic [31:0] bus_sel,
  output logic [5:0]  ALU_Sel,
  output logic        read,
  output logic        write,
  output logic        incPC,
  output logic        conIn,
  output logic        outport_en,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        run
);
  import ctrl_pkg::*;

  logic z_ld;
  logic alu_step;
  logic rr_or_imm;

  always_comb begin
    reg_enable = '0;
    bus_sel    = '0;
    ALU_Sel    = '0;
    read       = 1'b0;
    write      = 1'b0;
    incPC      = 1'b0;
    conIn      = 1'b0;
    outport_en = 1'b0;
    Gra        = 1'b0;
    Grb        = 1'b0;
    Grc        = 1'b0;
    Rin        = 1'b0;
    Rout       = 1'b0;
    BAout      = 1'b0;
    run        = 1'b1;
    z_ld       = 1'b0;
    alu_step   = 1'b0;
    rr_or_imm  = is_alu_rr(opcode) || is_alu_imm(opcode);

    case (state)
      S_T0: begin
        bus_sel[BS_PC] = 1'b1; reg_enable[RE_MAR] = 1'b1; incPC = 1'b1;
      end
      S_T1: begin
        read = 1'b1; reg_enable[RE_MDR] = 1'b1;
      end
      S_T2: begin
        bus_sel[BS_MDR] = 1'b1; reg_enable[RE_IR] = 1'b1;
      end
      S_T3: begin
        if (rr_or_imm) begin
          Grb = 1'b1; Rout = 1'b1; reg_enable[RE_Y] = 1'b1;
        end else begin
          case (opcode)
            OP_LD, OP_LDI, OP_ST: begin Grb = 1'b1; BAout = 1'b1; reg_enable[RE_Y] = 1'b1; end
            OP_MUL, OP_DIV: begin Gra = 1'b1; Rout = 1'b1; reg_enable[RE_Y] = 1'b1; end
            OP_NEG, OP_NOT: begin Grb = 1'b1; Rout = 1'b1; z_ld = 1'b1; alu_step = 1'b1; end
            OP_BR:   begin Gra = 1'b1; Rout = 1'b1; conIn = 1'b1; end
            OP_JR:   begin Gra = 1'b1; Rout = 1'b1; reg_enable[RE_PC] = 1'b1; end
            OP_JAL:  begin bus_sel[BS_PC] = 1'b1; Grb = 1'b1; Rin = 1'b1; end
            OP_IN:   begin bus_sel[BS_IN] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; outport_en = 1'b1; end
            OP_MFHI: begin bus_sel[BS_HI] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_MFLO: begin bus_sel[BS_LO] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            default: ;
          endcase
        end
      end
      S_T4: begin
        if (is_alu_rr(opcode)) begin
          Grc = 1'b1; Rout = 1'b1; z_ld = 1'b1; alu_step = 1'b1;
        end else if (is_alu_imm(opcode)) begin
          bus_sel[BS_C] = 1'b1; z_ld = 1'b1; alu_step = 1'b1;
        end else begin
          case (opcode)
            OP_LD, OP_LDI, OP_ST: begin bus_sel[BS_C] = 1'b1; z_ld = 1'b1; end
            OP_MUL, OP_DIV: begin Grb = 1'b1; Rout = 1'b1; z_ld = 1'b1; alu_step = 1'b1; end
            OP_NEG, OP_NOT: begin bus_sel[BS_ZL] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_BR:  begin bus_sel[BS_PC] = 1'b1; reg_enable[RE_Y] = 1'b1; end
            OP_JAL: begin Gra = 1'b1; Rout = 1'b1; reg_enable[RE_PC] = 1'b1; end
            default: ;
          endcase
        end
      end
      S_T5: begin
        if (rr_or_imm || opcode == OP_LDI) begin
          bus_sel[BS_ZL] = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else begin
          case (opcode)
            OP_LD, OP_ST:   begin bus_sel[BS_ZL] = 1'b1; reg_enable[RE_MAR] = 1'b1; end
            OP_MUL, OP_DIV: begin bus_sel[BS_ZL] = 1'b1; reg_enable[RE_LO] = 1'b1; end
            OP_BR:          begin bus_sel[BS_C] = 1'b1; z_ld = 1'b1; end
            default: ;
          endcase
        end
      end
      S_T6: begin
        case (opcode)
          OP_LD:  begin read = 1'b1; reg_enable[RE_MDR] = 1'b1; end
          OP_ST:  begin Gra = 1'b1; Rout = 1'b1; reg_enable[RE_MDR] = 1'b1; end
          OP_MUL, OP_DIV: begin bus_sel[BS_ZH] = 1'b1; reg_enable[RE_HI] = 1'b1; end
          // Branch target only reaches PC when the latched condition holds.
          OP_BR: if (con) begin bus_sel[BS_ZL] = 1'b1; reg_enable[RE_PC] = 1'b1; end
          default: ;
        endcase
      end
      S_T7: begin
        case (opcode)
          OP_LD: begin bus_sel[BS_MDR] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_ST: write = 1'b1;
          default: ;
        endcase
      end
      S_HALT: run = 1'b0;
      default: ;
    endcase

    if (z_ld) begin
      reg_enable[RE_ZH] = 1'b1;
      reg_enable[RE_ZL] = 1'b1;
    end
    if (alu_step)  ALU_Sel = {1'b0, opcode};
    else if (z_ld) ALU_Sel = ALU_ADD;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: T-step state register and next-state logic; the
// per-step control decode lives in ctrl_decode.
module control_sequencer #(
  parameter logic [5:0] ALU_ADD = 6'd3
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con,
  output logic [31:0] reg_enable,
  output logic [31:0] bus_sel,
  output logic [5:0]  ALU_Sel,
  output logic        read,
  output logic        write,
  output logic        incPC,
  output logic        conIn,
  output logic        outport_en,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        run
);
  import ctrl_pkg::*;

  state_e     state_q, state_d;
  state_e     last;
  logic [4:0] opcode;
  logic       unused_ir;

  assign opcode    = ir[31:27];
  assign unused_ir = ^ir[26:0];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= S_RST;
    else      state_q <= state_d;
  end

  // The T2 decision uses ir as presented during T2.
  always_comb begin
    last    = last_step(opcode);
    state_d = state_q;
    case (state_q)
      S_RST:  state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2: begin
        if (opcode == OP_HALT)  state_d = S_HALT;
        else if (last == S_T2)  state_d = S_T0;
        else                    state_d = S_T3;
      end
      S_T3:   state_d = (last == S_T3) ? S_T0 : S_T4;
      S_T4:   state_d = (last == S_T4) ? S_T0 : S_T5;
      S_T5:   state_d = (last == S_T5) ? S_T0 : S_T6;
      S_T6:   state_d = (last == S_T6) ? S_T0 : S_T7;
      S_T7:   state_d = S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  ctrl_decode #(.ALU_ADD(ALU_ADD)) u_decode (
    .state      (state_q),
    .opcode     (opcode),
    .con        (con),
    .reg_enable (reg_enable),
    .bus_sel    (bus_sel),
    .ALU_Sel    (ALU_Sel),
    .read       (read),
    .write      (write),
    .incPC      (incPC),
    .conIn      (conIn),
    .outport_en (outport_en),
    .Gra        (Gra),
    .Grb        (Grb),
    .Grc        (Grc),
    .Rin        (Rin),
    .Rout       (Rout),
    .BAout      (BAout),
    .run        (run)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-instruction step tables drive an expected
// queue that is compared against the packed control outputs every cycle.
module tb_control_sequencer;

  localparam int W = 82;

  localparam logic [31:0] R_HI  = 32'h0001_0000;
  localparam logic [31:0] R_LO  = 32'h0002_0000;
  localparam logic [31:0] R_Z   = 32'h000C_0000;
  localparam logic [31:0] R_PC  = 32'h0010_0000;
  localparam logic [31:0] R_IR  = 32'h0020_0000;
  localparam logic [31:0] R_MDR = 32'h0040_0000;
  localparam logic [31:0] R_MAR = 32'h0080_0000;
  localparam logic [31:0] R_Y   = 32'h0100_0000;

  localparam logic [31:0] B_HI  = 32'h0001_0000;
  localparam logic [31:0] B_LO  = 32'h0002_0000;
  localparam logic [31:0] B_ZH  = 32'h0004_0000;
  localparam logic [31:0] B_ZL  = 32'h0008_0000;
  localparam logic [31:0] B_PC  = 32'h0010_0000;
  localparam logic [31:0] B_MDR = 32'h0020_0000;
  localparam logic [31:0] B_IN  = 32'h0040_0000;
  localparam logic [31:0] B_C   = 32'h0080_0000;

  localparam logic [11:0] C_RD  = 12'h800;
  localparam logic [11:0] C_WR  = 12'h400;
  localparam logic [11:0] C_INC = 12'h200;
  localparam logic [11:0] C_CON = 12'h100;
  localparam logic [11:0] C_OUT = 12'h080;
  localparam logic [11:0] C_GRA = 12'h040;
  localparam logic [11:0] C_GRB = 12'h020;
  localparam logic [11:0] C_GRC = 12'h010;
  localparam logic [11:0] C_RIN = 12'h008;
  localparam logic [11:0] C_ROT = 12'h004;
  localparam logic [11:0] C_BA  = 12'h002;
  localparam logic [11:0] C_RUN = 12'h001;

  typedef struct {
    logic [4:0]  op;
    logic [1:0]  cn;    // 0/1 = con value required, 2 = either
    int          step;
    logic [31:0] re;
    logic [31:0] bs;
    logic [5:0]  alu;
    logic [11:0] ctl;
  } step_t;

  typedef struct {
    logic [4:0] op;
    logic       cn;
    int         n;
    string      name;
  } instr_t;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] ir  = '0;
  logic        con = 1'b0;

  always #5 clk = ~clk;

  logic [31:0] reg_enable, bus_sel;
  logic [5:0]  ALU_Sel;
  logic read, write, incPC, conIn, outport_en, Gra, Grb, Grc, Rin, Rout, BAout, run;
  logic [W-1:0] act;

  control_sequencer dut (
    .clk(clk), .clr(clr), .ir(ir), .con(con),
    .reg_enable(reg_enable), .bus_sel(bus_sel), .ALU_Sel(ALU_Sel),
    .read(read), .write(write), .incPC(incPC), .conIn(conIn),
    .outport_en(outport_en), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAout(BAout), .run(run)
  );

  assign act = {reg_enable, bus_sel, ALU_Sel, read, write, incPC, conIn,
                outport_en, Gra, Grb, Grc, Rin, Rout, BAout, run};

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  step_t        steps[$];
  instr_t       instrs[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic add_step(input logic [4:0] op, input logic [1:0] cn, input int s,
                          input logic [31:0] re, input logic [31:0] bs,
                          input logic [5:0] alu, input logic [11:0] ctl);
    step_t e;
    e.op = op; e.cn = cn; e.step = s; e.re = re; e.bs = bs; e.alu = alu; e.ctl = ctl;
    steps.push_back(e);
  endtask

  function automatic logic [W-1:0] fetch_vec(input int c);
    logic [W-1:0] v;
    case (c)
      0:       v = {R_MAR, B_PC, 6'd0, C_INC | C_RUN};
      1:       v = {R_MDR, 32'h0, 6'd0, C_RD | C_RUN};
      default: v = {R_IR, B_MDR, 6'd0, C_RUN};
    endcase
    return v;
  endfunction

  function automatic logic [W-1:0] exec_vec(input logic [4:0] op, input logic cn, input int c);
    logic [W-1:0] v;
    if (c < 3) return fetch_vec(c);
    v = {32'h0, 32'h0, 6'd0, C_RUN};
    for (int i = 0; i < steps.size(); i++)
      if (steps[i].op == op && steps[i].step == c &&
          (steps[i].cn == 2'd2 || steps[i].cn == {1'b0, cn}))
        v = {steps[i].re, steps[i].bs, steps[i].alu, steps[i].ctl | C_RUN};
    return v;
  endfunction

  task automatic check_out(input string name, input int c);
    logic [W-1:0] e;
    e = exp_q.pop_front();
    n_checks++;
    if (act === e) n_pass++;
    else $display("FAIL %s step %0d: got %h expected %h", name, c, act, e);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input string name);
    @(negedge clk);
    clr = 1'b0;
    #1;
    exp_q.push_back({32'h0, 32'h0, 6'd0, C_RUN});
    check_out({name, "_rst"}, -1);
    @(negedge clk);
    clr = 1'b1;
  endtask

  task automatic run_instr(input instr_t t, input logic [31:0] ir_val);
    ir  = ir_val;
    con = t.cn;
    do_reset(t.name);
    for (int c = 0; c <= t.n; c++) begin
      @(negedge clk);
      exp_q.push_back((c == t.n) ? fetch_vec(0) : exec_vec(t.op, t.cn, c));
      check_out(t.name, c);
    end
  endtask

  task automatic add_instr(input logic [4:0] op, input logic cn, input int n, input string name);
    instr_t t;
    t.op = op; t.cn = cn; t.n = n; t.name = name;
    instrs.push_back(t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    instr_t t;

    // add r-type
    add_step(5'd3,  2, 3, R_Y, 0,    6'd0,  C_GRB | C_ROT);
    add_step(5'd3,  2, 4, R_Z, 0,    6'd3,  C_GRC | C_ROT);
    add_step(5'd3,  2, 5, 0,   B_ZL, 6'd0,  C_GRA | C_RIN);
    // addi
    add_step(5'd12, 2, 3, R_Y, 0,    6'd0,  C_GRB | C_ROT);
    add_step(5'd12, 2, 4, R_Z, B_C,  6'd12, 12'h0);
    add_step(5'd12, 2, 5, 0,   B_ZL, 6'd0,  C_GRA | C_RIN);
    // ldi
    add_step(5'd1,  2, 3, R_Y, 0,    6'd0,  C_GRB | C_BA);
    add_step(5'd1,  2, 4, R_Z, B_C,  6'd3,  12'h0);
    add_step(5'd1,  2, 5, 0,   B_ZL, 6'd0,  C_GRA | C_RIN);
    // ld
    add_step(5'd0,  2, 3, R_Y,   0,     6'd0, C_GRB | C_BA);
    add_step(5'd0,  2, 4, R_Z,   B_C,   6'd3, 12'h0);
    add_step(5'd0,  2, 5, R_MAR, B_ZL,  6'd0, 12'h0);
    add_step(5'd0,  2, 6, R_MDR, 0,     6'd0, C_RD);
    add_step(5'd0,  2, 7, 0,     B_MDR, 6'd0, C_GRA | C_RIN);
    // st
    add_step(5'd2,  2, 3, R_Y,   0,    6'd0, C_GRB | C_BA);
    add_step(5'd2,  2, 4, R_Z,   B_C,  6'd3, 12'h0);
    add_step(5'd2,  2, 5, R_MAR, B_ZL, 6'd0, 12'h0);
    add_step(5'd2,  2, 6, R_MDR, 0,    6'd0, C_GRA | C_ROT);
    add_step(5'd2,  2, 7, 0,     0,    6'd0, C_WR);
    // mul
    add_step(5'd15, 2, 3, R_Y,  0,    6'd0,  C_GRA | C_ROT);
    add_step(5'd15, 2, 4, R_Z,  0,    6'd15, C_GRB | C_ROT);
    add_step(5'd15, 2, 5, R_LO, B_ZL, 6'd0,  12'h0);
    add_step(5'd15, 2, 6, R_HI, B_ZH, 6'd0,  12'h0);
    // neg
    add_step(5'd17, 2, 3, R_Z, 0,    6'd17, C_GRB | C_ROT);
    add_step(5'd17, 2, 4, 0,   B_ZL, 6'd0,  C_GRA | C_RIN);
    // br
    add_step(5'd19, 2, 3, 0,    0,    6'd0, C_GRA | C_ROT | C_CON);
    add_step(5'd19, 2, 4, R_Y,  B_PC, 6'd0, 12'h0);
    add_step(5'd19, 2, 5, R_Z,  B_C,  6'd3, 12'h0);
    add_step(5'd19, 1, 6, R_PC, B_ZL, 6'd0, 12'h0);
    // jr, jal, in, out, mfhi, mflo
    add_step(5'd20, 2, 3, R_PC, 0,    6'd0, C_GRA | C_ROT);
    add_step(5'd21, 2, 3, 0,    B_PC, 6'd0, C_GRB | C_RIN);
    add_step(5'd21, 2, 4, R_PC, 0,    6'd0, C_GRA | C_ROT);
    add_step(5'd22, 2, 3, 0,    B_IN, 6'd0, C_GRA | C_RIN);
    add_step(5'd23, 2, 3, 0,    0,    6'd0, C_GRA | C_ROT | C_OUT);
    add_step(5'd24, 2, 3, 0,    B_HI, 6'd0, C_GRA | C_RIN);
    add_step(5'd25, 2, 3, 0,    B_LO, 6'd0, C_GRA | C_RIN);

    add_instr(5'd3,  1'b0, 6, "add");
    add_instr(5'd12, 1'b1, 6, "addi");
    add_instr(5'd1,  1'b0, 6, "ldi");
    add_instr(5'd0,  1'b1, 8, "ld");
    add_instr(5'd2,  1'b0, 8, "st");
    add_instr(5'd15, 1'b0, 7, "mul");
    add_instr(5'd17, 1'b1, 5, "neg");
    add_instr(5'd19, 1'b0, 7, "br_con0");
    add_instr(5'd19, 1'b1, 7, "br_con1");
    add_instr(5'd20, 1'b0, 4, "jr");
    add_instr(5'd21, 1'b0, 5, "jal");
    add_instr(5'd22, 1'b0, 4, "in");
    add_instr(5'd23, 1'b1, 4, "out");
    add_instr(5'd24, 1'b0, 4, "mfhi");
    add_instr(5'd25, 1'b0, 4, "mflo");
    add_instr(5'd26, 1'b0, 3, "nop");
    add_instr(5'd30, 1'b0, 3, "undef");

    #3;
    for (int i = 0; i < instrs.size(); i++) begin
      t = instrs[i];
      if (t.op == 5'd3) run_instr(t, 32'h1A23_0000);
      else run_instr(t, {t.op, 27'(32'h0123_4567 + $urandom_range(0, 255))});
    end

    // halt: run drops after T2, everything stays quiet, clr pulse restarts
    ir = {5'd27, 27'h0};
    do_reset("halt");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      exp_q.push_back(fetch_vec(c));
      check_out("halt_fetch", c);
    end
    for (int c = 3; c < 23; c++) begin
      @(negedge clk);
      exp_q.push_back('0);
      check_out("halt_idle", c);
    end
    #2 clr = 1'b0;
    #1;
    exp_q.push_back({32'h0, 32'h0, 6'd0, C_RUN});
    check_out("halt_clr", -1);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    exp_q.push_back(fetch_vec(0));
    check_out("halt_restart", 0);

    // clr asserted mid-ld (T5): outputs clear with no clock edge
    t.op = 5'd0; t.cn = 1'b0; t.n = 8; t.name = "ld_abort";
    ir = 32'h0000_0010;
    con = 1'b0;
    do_reset("ld_abort");
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      exp_q.push_back(exec_vec(t.op, t.cn, c));
      check_out("ld_abort", c);
    end
    #2 clr = 1'b0;
    #1;
    exp_q.push_back({32'h0, 32'h0, 6'd0, C_RUN});
    check_out("async_clr", 5);
    @(negedge clk);
    clr = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      exp_q.push_back((c == 8) ? fetch_vec(0) : exec_vec(t.op, t.cn, c));
      check_out("ld_after_clr", c);
    end

    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
